control_medidor_frec: RTL and testbench

- Scan controller for the frequency meter (MEDIDOR_FREC).
- Steps an oscillator-select mux through N_OSC sources and, for each source, waits for the mux output to settle, enables the meter, waits for its lock, and captures the count.
- Streams one result per source on a valid/ready interface to the host/UART layer.
- Single clock domain; the meter's enable/lock/out connect directly to this block.

---
 rtl/control_medidor_frec.sv | 181 ++++++++++++++++++
 tb/tb_control_medidor_frec.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_medidor_frec.sv
// control_medidor_frec: scan controller for the MEDIDOR_FREC frequency meter.
// Steps the oscillator mux through N_OSC sources. For each source it waits for the
// mux output to settle, waits for a stale lock to clear, enables the meter, and
// captures the count, or reports a timeout. Results stream out on a valid/ready port.
// Optional build macro CONTROL_MEDIDOR_SUM_EN adds res_sum, a running sum of the
// non-timeout results of the current scan.
module control_medidor_frec #(
    parameter int unsigned N_OSC         = 16,
    parameter int unsigned SEL_WIDTH     = 4,
    parameter int unsigned OUT_WIDTH     = 32,
    parameter int unsigned SETTLE        = 8,
    parameter int unsigned TIMEOUT_WIDTH = 24
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [4:0]           resol_in,
    output logic [SEL_WIDTH-1:0] sel,
    output logic                 meas_enable,
    output logic [4:0]           meas_resol,
    input  logic                 meas_lock,
    input  logic [OUT_WIDTH-1:0] meas_out,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [OUT_WIDTH-1:0] res_data,
    output logic [SEL_WIDTH-1:0] res_index,
    output logic                 res_timeout,
`ifdef CONTROL_MEDIDOR_SUM_EN
    output logic [OUT_WIDTH+SEL_WIDTH-1:0] res_sum,
`endif
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned          SCW         = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SCW-1:0]       SETTLE_LAST = SCW'(SETTLE - 1);
    localparam logic [SEL_WIDTH-1:0] SEL_LAST    = SEL_WIDTH'(N_OSC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_WAIT_UNLOCK,
        S_MEASURE,
        S_OUTPUT,
        S_DONE
    } state_t;

    state_t                   state_q;
    logic [SCW-1:0]           settle_cnt_q;
    logic [TIMEOUT_WIDTH-1:0] tmo_q;
    logic [TIMEOUT_WIDTH-1:0] tmo_d;
    logic [SEL_WIDTH-1:0]     sel_q;
    logic                     meas_enable_q;
    logic [4:0]               resol_q;
    logic                     res_valid_q;
    logic [OUT_WIDTH-1:0]     res_data_q;
    logic [SEL_WIDTH-1:0]     res_index_q;
    logic                     res_timeout_q;
    logic                     busy_q;
    logic                     done_q;

    assign sel         = sel_q;
    assign meas_enable = meas_enable_q;
    assign meas_resol  = resol_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_index   = res_index_q;
    assign res_timeout = res_timeout_q;
    assign busy        = busy_q;
    assign done        = done_q;

    // Next value of the lock-timeout counter; timeout fires when it would reach all-ones
    always_comb begin
        tmo_d = tmo_q + TIMEOUT_WIDTH'(1);
    end

    // Scan sequencer with registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            settle_cnt_q  <= '0;
            tmo_q         <= '0;
            sel_q         <= '0;
            meas_enable_q <= 1'b0;
            resol_q       <= '0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_index_q   <= '0;
            res_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        resol_q      <= resol_in;
                        sel_q        <= '0;
                        settle_cnt_q <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        settle_cnt_q <= '0;
                        state_q      <= S_WAIT_UNLOCK;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + SCW'(1);
                    end
                end
                S_WAIT_UNLOCK: begin
                    if (!meas_lock) begin
                        tmo_q         <= '0;
                        meas_enable_q <= 1'b1;
                        state_q       <= S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    tmo_q <= tmo_d;
                    // Lock is tested first so it wins a same-cycle timeout.
                    if (meas_lock) begin
                        res_data_q    <= meas_out;
                        res_index_q   <= sel_q;
                        res_timeout_q <= 1'b0;
                        res_valid_q   <= 1'b1;
                        meas_enable_q <= 1'b0;
                        state_q       <= S_OUTPUT;
                    end else if (&tmo_d) begin
                        res_data_q    <= '0;
                        res_index_q   <= sel_q;
                        res_timeout_q <= 1'b1;
                        res_valid_q   <= 1'b1;
                        meas_enable_q <= 1'b0;
                        state_q       <= S_OUTPUT;
                    end
                end
                S_OUTPUT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        if (sel_q == SEL_LAST) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_DONE;
                        end else begin
                            sel_q        <= sel_q + SEL_WIDTH'(1);
                            settle_cnt_q <= '0;
                            state_q      <= S_SETTLE;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CONTROL_MEDIDOR_SUM_EN
    logic [OUT_WIDTH+SEL_WIDTH-1:0] res_sum_q;

    assign res_sum = res_sum_q;

    // Running sum of non-timeout results, cleared when a scan starts
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            res_sum_q <= '0;
        end else if (state_q == S_IDLE && start) begin
            res_sum_q <= '0;
        end else if (state_q == S_OUTPUT && res_ready && !res_timeout_q) begin
            res_sum_q <= res_sum_q + (OUT_WIDTH+SEL_WIDTH)'(res_data_q);
        end
    end
`else
    // No running sum in this build.
`endif

endmodule

// File: tb/tb_control_medidor_frec.sv
// tb_control_medidor_frec: randomized bench for control_medidor_frec with a meter model
// and a timeline-based reference model compared against the DUT every cycle.
module tb_control_medidor_frec;

    localparam int unsigned N   = 4;
    localparam int unsigned SW  = 4;
    localparam int unsigned OW  = 32;
    localparam int unsigned ST  = 8;
    localparam int unsigned TW  = 8;
    localparam int          TMO = (1 << TW) - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [4:0]    resol_in = '0;
    logic [SW-1:0] sel;
    logic          meas_enable;
    logic [4:0]    meas_resol;
    logic          meas_lock = 1'b0;
    logic [OW-1:0] meas_out = '0;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic [OW-1:0] res_data;
    logic [SW-1:0] res_index;
    logic          res_timeout;
    logic          busy;
    logic          done;
`ifdef CONTROL_MEDIDOR_SUM_EN
    logic [OW+SW-1:0] res_sum;
`endif

    control_medidor_frec #(
        .N_OSC(N), .SEL_WIDTH(SW), .OUT_WIDTH(OW), .SETTLE(ST), .TIMEOUT_WIDTH(TW)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .resol_in(resol_in),
        .sel(sel), .meas_enable(meas_enable), .meas_resol(meas_resol),
        .meas_lock(meas_lock), .meas_out(meas_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_index(res_index), .res_timeout(res_timeout),
`ifdef CONTROL_MEDIDOR_SUM_EN
        .res_sum(res_sum),
`endif
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Meter configuration
    int          delay_cfg [N];
    bit          nolock_cfg[N];
    logic [31:0] data_cfg  [N];
    int          hold_cfg = 0;
    int          rmode    = 0;   // 0: always ready, 1: stall result 1 for 20 cycles, 2: random

    // Reference model: expected outputs for the current cycle plus timeline bookkeeping
    int             cyc = 0;
    logic           e_busy = 0, e_done = 0, e_valid = 0, e_en = 0, e_to = 0;
    int             e_sel = 0, e_idx = 0;
    logic [OW-1:0]  e_data = '0;
    logic [4:0]     e_resol = '0;
    logic [OW+SW-1:0] e_sum = '0;
    int             gate = -1, ecnt = 0, m_cnt = 0, m_hold = 0, n_done = 0;
    int             ev_start = 0;
    int             ev_en[N], ev_valid[N], ev_xfer[N];
    logic [OW-1:0]  ev_data[N];
    logic           ev_to[N];

    // Meter model, reference model update and per-cycle comparison
    always @(negedge clock) begin : model
        int si;
        cyc++;
        si = int'(sel);
        if (reset) begin
            m_cnt = 0; m_hold = 0; meas_lock = 1'b0;
        end else if (meas_enable) begin
            m_cnt++;
            m_hold = hold_cfg;
            meas_lock = (si < N) && !nolock_cfg[si] && (m_cnt > delay_cfg[si]);
            meas_out  = meas_lock ? data_cfg[si] : $urandom;
        end else begin
            m_cnt = 0;
            if (meas_lock && m_hold > 0) m_hold--;
            else meas_lock = 1'b0;
            if (!meas_lock) meas_out = $urandom;
        end

        if (reset) begin
            e_busy = 0; e_done = 0; e_valid = 0; e_en = 0; e_to = 0;
            e_sel = 0; e_idx = 0; e_data = '0; e_resol = '0; e_sum = '0;
            gate = -1; ecnt = 0;
        end

        check("sel", sel, e_sel);
        check("meas_enable", meas_enable, e_en);
        check("meas_resol", meas_resol, e_resol);
        check("res_valid", res_valid, e_valid);
        check("busy", busy, e_busy);
        check("done", done, e_done);
        if (e_valid || reset) begin
            check("res_data", res_data, e_data);
            check("res_index", res_index, e_idx);
            check("res_timeout", res_timeout, e_to);
        end
`ifdef CONTROL_MEDIDOR_SUM_EN
        check("res_sum", res_sum, e_sum);
`endif

        if (!reset) begin
            if (!e_busy && !e_done) begin
                if (start) begin
                    e_busy = 1; e_sel = 0; e_resol = resol_in; e_sum = '0;
                    gate = cyc + 1 + ST; ev_start = cyc;
                end
            end else if (e_done) begin
                e_done = 0;
            end else if (gate >= 0) begin
                if (cyc >= gate && !meas_lock) begin
                    e_en = 1; ecnt = 0; gate = -1; ev_en[e_sel] = cyc + 1;
                end
            end else if (e_en) begin
                ecnt++;
                if (meas_lock) begin
                    e_en = 0; e_valid = 1; e_data = meas_out; e_to = 0; e_idx = e_sel;
                    ev_valid[e_sel] = cyc + 1;
                end else if (ecnt == TMO) begin
                    e_en = 0; e_valid = 1; e_data = '0; e_to = 1; e_idx = e_sel;
                    ev_valid[e_sel] = cyc + 1;
                end
            end else if (e_valid && res_ready) begin
                e_valid = 0;
                ev_xfer[e_sel] = cyc; ev_data[e_sel] = e_data; ev_to[e_sel] = e_to;
                if (!e_to) e_sum = e_sum + (OW+SW)'(e_data);
                if (e_sel == N - 1) begin
                    e_done = 1; e_busy = 0; n_done++;
                end else begin
                    e_sel++; gate = cyc + 1 + ST;
                end
            end
        end
    end

    // Consumer ready generation
    int stall_cnt = 0;
    always @(posedge clock) begin
        #1;
        if (!busy) stall_cnt = 0;
        if (rmode == 0) begin
            res_ready = 1'b1;
        end else if (rmode == 1) begin
            if (res_valid && res_index == 1 && stall_cnt < 20) begin
                res_ready = 1'b0; stall_cnt++;
            end else begin
                res_ready = 1'b1;
            end
        end else begin
            res_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic cfg_basic();
        for (int i = 0; i < N; i++) begin
            delay_cfg[i] = 100; nolock_cfg[i] = 0; data_cfg[i] = 1000 + i;
        end
        hold_cfg = 0;
    endtask

    task automatic pulse_start();
        @(posedge clock); #1;
        start = 1'b1; resol_in = 5'($urandom);
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic do_scan(input int budget);
        int k;
        pulse_start();
        k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(posedge clock); #1; k++;
        end
        if (k >= budget) begin
            n_chk++;
            $display("FAIL scan_budget: no done pulse within %0d cycles", budget);
        end
        @(posedge clock); #1;
    endtask

    initial begin : stim
        int k;
        cfg_basic();
        #1 reset = 1'b1;
        #2;
        check("rst_sel", sel, 0);
        check("rst_meas_enable", meas_enable, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;

        // Nominal scan: lock 100 cycles after enable, data 1000+index
        do_scan(3000);
        check("A_done_count", n_done, 1);
        check("A_start_to_enable", ev_en[0] - ev_start, 10);
        check("A_start_to_valid", ev_valid[0] - ev_start, 111);
        for (int i = 0; i < N; i++) begin
            check("A_data", ev_data[i], 1000 + i);
            check("A_timeout", ev_to[i], 0);
        end
`ifdef CONTROL_MEDIDOR_SUM_EN
        check("A_sum", e_sum, 4006);
`endif

        // Consumer stalls result 1 for 20 cycles
        rmode = 1;
        do_scan(3000);
        check("B_stall_len", ev_xfer[1] - ev_valid[1] + 1, 21);
        check("B_data1", ev_data[1], 1001);
        rmode = 0;

        // Index 2 never locks; lock lingers 12 cycles after enable drops
        cfg_basic();
        nolock_cfg[2] = 1;
        hold_cfg = 12;
        do_scan(4000);
        check("C_timeout_flag", ev_to[2], 1);
        check("C_timeout_data", ev_data[2], 0);
        check("C_timeout_delay", ev_valid[2] - ev_en[2], 255);
        check("C_unlock_wait", ev_en[1] - ev_xfer[0], 13);
        check("C_data3", ev_data[3], 1003);
`ifdef CONTROL_MEDIDOR_SUM_EN
        check("C_sum", e_sum, 3004);
`endif

        // Reset asserted while index 1 is being measured
        cfg_basic();
        pulse_start();
        k = 0;
        while (!(sel == 1 && meas_enable === 1'b1) && k < 2000) begin
            @(posedge clock); #1; k++;
        end
        if (k >= 2000) begin
            n_chk++;
            $display("FAIL reset_setup: index 1 measure not reached");
        end
        @(posedge clock); #2 reset = 1'b1;
        #1;
        check("R_sel", sel, 0);
        check("R_meas_enable", meas_enable, 0);
        check("R_meas_resol", meas_resol, 0);
        check("R_res_valid", res_valid, 0);
        check("R_res_data", res_data, 0);
        check("R_res_index", res_index, 0);
        check("R_res_timeout", res_timeout, 0);
        check("R_busy", busy, 0);
        check("R_done", done, 0);
`ifdef CONTROL_MEDIDOR_SUM_EN
        check("R_res_sum", res_sum, 0);
`endif
        @(posedge clock); #2 reset = 1'b0;
        do_scan(3000);
        check("D_start_to_valid", ev_valid[0] - ev_start, 111);
        check("D_data0", ev_data[0], 1000);

        // Randomized scans
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) begin
                delay_cfg[i]  = $urandom_range(0, 300);
                nolock_cfg[i] = ($urandom_range(0, 5) == 0);
                data_cfg[i]   = $urandom;
            end
            hold_cfg = $urandom_range(0, 20);
            rmode = 2;
            do_scan(8000);
        end
        rmode = 0;
        repeat (3) @(posedge clock);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
